// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/grant/response and memory-drive signals between the core,
// the arbiter and the shared single-port memory. Suffixes are arbiter-relative.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            ls_req_i;
  logic            ls_we_i;
  logic [AW-1:0]   ls_addr_i;
  logic [XLEN-1:0] ls_wdata_i;
  logic            ls_gnt_o;
  logic            ls_rvalid_o;
  logic [XLEN-1:0] ls_rdata_o;

  logic            mem_we_o;
  logic [AW-1:0]   mem_read_addr_o;
  logic [AW-1:0]   mem_write_addr_o;
  logic [XLEN-1:0] mem_write_data_o;
  logic [XLEN-1:0] mem_read_data_i;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, mem_read_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           mem_we_o, mem_read_addr_o, mem_write_addr_o, mem_write_data_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, mem_read_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           mem_we_o, mem_read_addr_o, mem_write_addr_o, mem_write_data_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one single-port memory: LS-first with a starvation
// counter that forces IF through, and a one-cycle registered response.
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS_RD, OWN_LS_WR} owner_e;

  owner_e          own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [AW-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            if_gnt, ls_gnt, force_if;

  assign force_if = (cnt_q == CW'(MAX_WAIT));

  // Grants are forced low while in reset so nothing reaches the memory.
  always_comb begin
    ls_gnt = 1'b0;
    if_gnt = 1'b0;
    if (rst_ni) begin
      ls_gnt = bus.ls_req_i && !(bus.if_req_i && force_if);
      if_gnt = bus.if_req_i && !ls_gnt;
    end
  end

  always_comb begin
    cnt_d      = '0;
    own_d      = OWN_NONE;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (bus.if_req_i && !if_gnt)
      cnt_d = force_if ? cnt_q : cnt_q + CW'(1);
    if (if_gnt) begin
      own_d      = OWN_IF;
      if_rdata_d = bus.mem_read_data_i;
      raddr_d    = bus.if_addr_i;
    end else if (ls_gnt) begin
      if (bus.ls_we_i) begin
        own_d      = OWN_LS_WR;
        ls_rdata_d = '0;
        waddr_d    = bus.ls_addr_i;
        wdata_d    = bus.ls_wdata_i;
      end else begin
        own_d      = OWN_LS_RD;
        ls_rdata_d = bus.mem_read_data_i;
        raddr_d    = bus.ls_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_q      <= OWN_NONE;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      own_q      <= own_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // The _d values carry the live address when granted and the held one otherwise.
  assign bus.if_gnt_o         = if_gnt;
  assign bus.ls_gnt_o         = ls_gnt;
  assign bus.mem_we_o         = ls_gnt && bus.ls_we_i;
  assign bus.mem_read_addr_o  = rst_ni ? raddr_d : '0;
  assign bus.mem_write_addr_o = rst_ni ? waddr_d : '0;
  assign bus.mem_write_data_o = rst_ni ? wdata_d : '0;
  assign bus.if_rvalid_o      = (own_q == OWN_IF);
  assign bus.ls_rvalid_o      = (own_q == OWN_LS_RD) || (own_q == OWN_LS_WR);
  assign bus.if_rdata_o       = if_rdata_q;
  assign bus.ls_rdata_o       = ls_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, arbitration model and
// a response queue checked one cycle after each grant.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int MW   = 4;

  typedef struct {
    logic        iv;
    logic        lv;
    logic [31:0] id;
    logic [31:0] ld;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic mem_init;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  exp_t        q[$];
  int          cnt_m;
  logic [31:0] hold_if, hold_ls;
  int          errors = 0;
  int          checks = 0;

  mem_port_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  mem_port_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_WAIT(MW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | (i * 32'h0000_0101);
  endfunction

  // Environment memory: async read, write on the rising edge.
  assign bus.mem_read_data_i = mem[bus.mem_read_addr_o[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (bus.mem_we_o) begin
      mem[bus.mem_write_addr_o[7:2]] <= bus.mem_write_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t n;
    cnt_m   = 0;
    hold_if = '0;
    hold_ls = '0;
    q.delete();
    n.iv = 1'b0; n.lv = 1'b0; n.id = '0; n.ld = '0;
    q.push_back(n);
  endtask

  // Checks the cycle whose inputs are already driven, then advances to posedge+1.
  task automatic step();
    exp_t r, n;
    logic ex_if, ex_ls;
    @(negedge clk);
    ex_ls = bus.ls_req_i && !(bus.if_req_i && cnt_m == MW);
    ex_if = bus.if_req_i && !ex_ls;
    chk("if_gnt", bus.if_gnt_o, ex_if);
    chk("ls_gnt", bus.ls_gnt_o, ex_ls);
    chk("gnt_onehot", bus.if_gnt_o & bus.ls_gnt_o, 0);
    if (ex_if) begin
      chk("rd_addr_if", bus.mem_read_addr_o, bus.if_addr_i);
      chk("we_if", bus.mem_we_o, 0);
    end else if (ex_ls && bus.ls_we_i) begin
      chk("wr_addr", bus.mem_write_addr_o, bus.ls_addr_i);
      chk("wr_data", bus.mem_write_data_o, bus.ls_wdata_i);
      chk("we_wr", bus.mem_we_o, 1);
    end else if (ex_ls) begin
      chk("rd_addr_ls", bus.mem_read_addr_o, bus.ls_addr_i);
      chk("we_ls_rd", bus.mem_we_o, 0);
    end else begin
      chk("we_idle", bus.mem_we_o, 0);
    end
    if (q.size() == 0) begin
      chk("queue_empty", 1, 0);
      r.iv = 1'b0; r.lv = 1'b0; r.id = hold_if; r.ld = hold_ls;
    end else begin
      r = q.pop_front();
    end
    chk("if_rvalid", bus.if_rvalid_o, r.iv);
    chk("if_rdata", bus.if_rdata_o, r.id);
    chk("ls_rvalid", bus.ls_rvalid_o, r.lv);
    chk("ls_rdata", bus.ls_rdata_o, r.ld);
    if (ex_if) hold_if = ref_mem[bus.if_addr_i[7:2]];
    if (ex_ls) begin
      if (bus.ls_we_i) begin
        hold_ls = '0;
        ref_mem[bus.ls_addr_i[7:2]] = bus.ls_wdata_i;
      end else begin
        hold_ls = ref_mem[bus.ls_addr_i[7:2]];
      end
    end
    n.iv = ex_if; n.lv = ex_ls; n.id = hold_if; n.ld = hold_ls;
    q.push_back(n);
    if (bus.if_req_i && !ex_if) cnt_m = (cnt_m == MW) ? MW : cnt_m + 1;
    else cnt_m = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld);
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.ls_req_i   = lr;
    bus.ls_we_i    = lw;
    bus.ls_addr_i  = la;
    bus.ls_wdata_i = ld;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    mem_init = 1'b1;
    rst_ni   = 1'b0;
    drive(1, 32'h4, 1, 0, 32'h20, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_if_gnt", bus.if_gnt_o, 0);
    chk("rst_ls_gnt", bus.ls_gnt_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_ls_rvalid", bus.ls_rvalid_o, 0);
    chk("rst_rd_addr", bus.mem_read_addr_o, 0);
    chk("rst_wr_addr", bus.mem_write_addr_o, 0);
    chk("rst_wr_data", bus.mem_write_data_o, 0);
    chk("rst_if_rdata", bus.if_rdata_o, 0);
    chk("rst_ls_rdata", bus.ls_rdata_o, 0);
    rst_ni = 1'b1;
    model_reset();
    step();

    // Write then IF read of the same word on the next cycle.
    drive(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    step();
    drive(1, 32'h10, 0, 0, 32'h0, 32'h0);
    step();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    chk("raw_if_data", bus.if_rdata_o, 32'hDEAD_BEEF);

    // Contention: IF forced through every fifth cycle.
    drive(1, 32'hC, 1, 0, 32'h8, 32'h0);
    for (int i = 0; i < 11; i++) step();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();

    // IF streaming reads.
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    drive(1, 32'h4, 0, 0, 32'h0, 32'h0);
    step();
    drive(1, 32'h8, 0, 0, 32'h0, 32'h0);
    step();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    // Reset pulse after an LS read grant discards the response.
    drive(0, 32'h0, 1, 0, 32'h18, 32'h0);
    @(negedge clk);
    chk("pre_rst_ls_gnt", bus.ls_gnt_o, 1);
    #1;
    rst_ni = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("mid_rst_ls_rvalid", bus.ls_rvalid_o, 0);
    chk("mid_rst_ls_gnt", bus.ls_gnt_o, 0);
    chk("mid_rst_we", bus.mem_we_o, 0);
    @(posedge clk);
    #1;
    chk("post_edge_ls_rvalid", bus.ls_rvalid_o, 0);
    rst_ni = 1'b1;
    model_reset();
    step();
    drive(1, 32'h24, 1, 0, 32'h28, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Read-then-write on one address, then read back.
    drive(0, 32'h0, 1, 0, 32'h14, 32'h0);
    step();
    drive(0, 32'h0, 1, 1, 32'h14, 32'h1234_5678);
    step();
    drive(0, 32'h0, 1, 0, 32'h14, 32'h0);
    step();
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    chk("rbw_readback", bus.ls_rdata_o, 32'h1234_5678);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
